// File: rtl/ctrl_datapath_if.sv
// Bus between the sequencing controller and ctrl_datapath: register load enables, mux/op
// selects and operands toward the datapath; registered result and status back.
interface ctrl_datapath_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic [2:0]       load;
    logic [4:0]       m;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             zero;
    logic             neg;
    logic [CNT_W-1:0] res_cnt;
    logic             err;

    modport master (
        output load, m, din_a, din_b,
        input  dout, dout_valid, zero, neg, res_cnt, err
    );

    modport slave (
        input  load, m, din_a, din_b,
        output dout, dout_valid, zero, neg, res_cnt, err
    );
endinterface

// File: rtl/ctrl_datapath.sv
// Three-register datapath with ALU, registered result/flags, saturating result counter and
// sticky protocol-error flag, driven by the sequencing controller's load/m selects.
module ctrl_datapath #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic            clk,
    input logic            rst,
    ctrl_datapath_if.slave bus
);
    logic [WIDTH-1:0] r0_q, r1_q, r2_q;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] mux0, mux1, mux2;
    logic             dout_valid_q, zero_q, neg_q, err_q, err_d;
    logic             rst_prev_q;
    logic [CNT_W-1:0] res_cnt_q;

    always_comb begin
        alu = '0;
        unique case ({bus.m[4], bus.m[3]})
            2'b00: alu = r0_q + r1_q;
            2'b01: alu = r0_q - r1_q;
            2'b10: alu = r0_q;
            2'b11: alu = r0_q ^ r1_q;
            default: alu = '0;
        endcase
    end

    assign mux0 = bus.m[0] ? alu  : bus.din_a;
    assign mux1 = bus.m[1] ? r0_q : bus.din_b;
    assign mux2 = bus.m[2] ? r1_q : alu;

    // Chained R0->R1 copy with R0<=alu, or any load in the first post-reset cycle.
    always_comb begin
        err_d = err_q;
        if (bus.load[1] && bus.m[1] && bus.load[0] && bus.m[0]) begin
            err_d = 1'b1;
        end
        if ((bus.load != 3'b000) && rst_prev_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q         <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            dout_valid_q <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            res_cnt_q    <= '0;
            err_q        <= 1'b0;
            rst_prev_q   <= 1'b1;
        end else begin
            if (bus.load[0]) r0_q <= mux0;
            if (bus.load[1]) r1_q <= mux1;
            if (bus.load[2]) begin
                r2_q   <= mux2;
                zero_q <= (alu == '0);
                neg_q  <= alu[WIDTH-1];
                if (res_cnt_q != {CNT_W{1'b1}}) begin
                    res_cnt_q <= res_cnt_q + 1'b1;
                end
            end
            dout_valid_q <= bus.load[2];
            err_q        <= err_d;
            rst_prev_q   <= 1'b0;
        end
    end

    assign bus.dout       = r2_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.zero       = zero_q;
    assign bus.neg        = neg_q;
    assign bus.res_cnt    = res_cnt_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_ctrl_datapath.sv
// Scoreboard bench for ctrl_datapath: directed scenarios then random load/m traffic, checked
// against an arithmetic register-transfer model.
module tb_ctrl_datapath;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int MASK    = (1 << WIDTH) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int dout;
        int zero;
        int neg;
        int cnt;
    } exp_t;

    logic clk;
    logic rst;
    ctrl_datapath_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    ctrl_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference state: register file, result count, flags.
    int r[3];
    int m_cnt = 0;
    int m_zero = 0;
    int m_neg = 0;
    int m_err = 0;
    int m_prev_rst = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rr, input logic [2:0] l, input logic [4:0] mm,
                              input logic [7:0] a, input logic [7:0] b);
        int alu;
        int nxt[3];
        if (rr) begin
            r = '{0, 0, 0};
            m_cnt = 0;
            m_zero = 0;
            m_neg = 0;
            m_err = 0;
            m_prev_rst = 1;
            return;
        end
        case ({mm[4], mm[3]})
            2'b00:   alu = (r[0] + r[1]) & MASK;
            2'b01:   alu = (r[0] - r[1]) & MASK;
            2'b10:   alu = r[0];
            default: alu = r[0] ^ r[1];
        endcase
        nxt[0] = mm[0] ? alu : int'(a);
        nxt[1] = mm[1] ? r[0] : int'(b);
        nxt[2] = mm[2] ? r[1] : alu;
        if (l[0] && l[1] && mm[0] && mm[1]) m_err = 1;
        if (l != 3'b000 && m_prev_rst != 0) m_err = 1;
        m_prev_rst = 0;
        if (l[2]) begin
            exp_t e;
            m_zero = (alu == 0) ? 1 : 0;
            m_neg  = (alu >> (WIDTH - 1)) & 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            e.dout = nxt[2];
            e.zero = m_zero;
            e.neg  = m_neg;
            e.cnt  = m_cnt;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            if (l[i]) r[i] = nxt[i];
        end
    endtask

    task automatic cyc(input logic rr, input logic [2:0] l, input logic [4:0] mm,
                       input logic [7:0] a, input logic [7:0] b);
        rst       = rr;
        bus.load  = l;
        bus.m     = mm;
        bus.din_a = a;
        bus.din_b = b;
        @(posedge clk);
        #1;
        model_step(rr, l, mm, a, b);
    endtask

    // Monitor: sampled on the falling edge, away from the register updates.
    initial begin
        forever begin
            @(negedge clk);
            chk("dout_valid", {31'b0, bus.dout_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.dout_valid === 1'b1) begin
                    chk("result_dout", 32'(bus.dout), e.dout);
                    chk("result_zero", {31'b0, bus.zero}, e.zero);
                    chk("result_neg", {31'b0, bus.neg}, e.neg);
                    chk("result_cnt", 32'(bus.res_cnt), e.cnt);
                end
            end
            chk("dout", 32'(bus.dout), r[2]);
            chk("res_cnt", 32'(bus.res_cnt), m_cnt);
            chk("zero", {31'b0, bus.zero}, m_zero);
            chk("neg", {31'b0, bus.neg}, m_neg);
            chk("err", {31'b0, bus.err}, m_err);
        end
    end

    initial begin
        r = '{0, 0, 0};
        // Reset held with loads asserted: nothing may load.
        cyc(1, 3'b111, 5'b00000, 8'hAA, 8'h55);
        cyc(1, 3'b111, 5'b00000, 8'hAA, 8'h55);
        cyc(0, 3'b000, 5'b00000, 8'h00, 8'h00);
        cyc(0, 3'b100, 5'b10000, 8'h00, 8'h00);   // view R0 (must still be 0)
        // Add path: 5 + 3.
        cyc(0, 3'b011, 5'b00000, 8'd5, 8'd3);
        cyc(0, 3'b100, 5'b00000, 8'd0, 8'd0);
        cyc(0, 3'b000, 5'b00000, 8'd0, 8'd0);
        // Subtract wrap: 2 - 3, then 7 - 7.
        cyc(0, 3'b011, 5'b00000, 8'd2, 8'd3);
        cyc(0, 3'b100, 5'b01000, 8'd0, 8'd0);
        cyc(0, 3'b011, 5'b00000, 8'd7, 8'd7);
        cyc(0, 3'b100, 5'b01000, 8'd0, 8'd0);
        // Parallel transfer over two cycles, no error.
        cyc(0, 3'b011, 5'b00000, 8'd9, 8'd4);
        cyc(0, 3'b010, 5'b00010, 8'd0, 8'd0);
        cyc(0, 3'b001, 5'b00000, 8'd1, 8'd0);
        cyc(0, 3'b100, 5'b00100, 8'd0, 8'd0);     // R2 <= R1 (9)
        cyc(0, 3'b100, 5'b10000, 8'd0, 8'd0);     // R2 <= R0 (1)
        // Chained transfer sets sticky err; then saturate the counter.
        cyc(0, 3'b011, 5'b00011, 8'd0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 3'b100, 5'($urandom), 8'($urandom), 8'($urandom));
        end
        // Mid-op reset, then idle.
        cyc(1, 3'b100, 5'b00000, 8'd1, 8'd1);
        cyc(0, 3'b000, 5'b00000, 8'd0, 8'd0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0), 3'($urandom), 5'($urandom),
                8'($urandom), 8'($urandom));
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
